// File: rtl/td4_sequencer.sv
// TD4 fetch/execute sequencer: latches the instruction, decodes strobes, holds the carry flag.
// Optional jump-to-self halt detection is enabled by defining HALT_DETECT_EN.
module td4_sequencer #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    input  logic [7:0]      instr,
    input  logic [PC_W-1:0] pc,
    input  logic            carry_in,
    output logic [1:0]      alu_sel,
    output logic [PC_W-1:0] imm,
    output logic            ld_a,
    output logic            ld_b,
    output logic            ld_out,
    output logic            pc_ld_n,
    output logic            pc_inc,
    output logic            c_flag,
    output logic            busy,
    output logic            halted
);

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {S_PAUSE, S_FETCH, S_EXEC, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_PAUSE, S_FETCH, S_EXEC} state_t;
`endif

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_ir;
    logic       r_c_flag;
    logic       r_step_q;
    logic [3:0] w_op;
    logic       w_step_edge;
    logic       w_jump_taken;
    logic       w_halt;

    assign w_op        = r_ir[7:4];
    assign w_step_edge = step & ~r_step_q;
    assign imm         = PC_W'(r_ir[3:0]);
    assign c_flag      = r_c_flag;
    assign busy        = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign w_jump_taken = (w_op == OP_JMP) || ((w_op == OP_JNC) && !r_c_flag);

`ifdef HALT_DETECT_EN
    assign w_halt = w_jump_taken && (imm == pc);
    assign halted = (r_state == S_HALT);
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc;
    assign w_halt      = 1'b0;
    assign halted      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_PAUSE;
            r_ir     <= '0;
            r_c_flag <= 1'b0;
            r_step_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_q <= step;
            if (r_state == S_FETCH)
                r_ir <= instr;
            // Only the two ADD forms leave a carry; everything else clears it.
            if (r_state == S_EXEC)
                r_c_flag <= ((w_op == OP_ADD_A) || (w_op == OP_ADD_B)) ? carry_in : 1'b0;
        end
    end

    always_comb begin
        w_next  = r_state;
        alu_sel = 2'b11;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_out  = 1'b0;
        pc_ld_n = 1'b1;
        pc_inc  = 1'b0;

        case (r_state)
            S_PAUSE: begin
                if (run || w_step_edge)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = run ? S_FETCH : S_PAUSE;
`ifdef HALT_DETECT_EN
                if (w_halt)
                    w_next = S_HALT;
`endif
                case (w_op)
                    OP_ADD_A:  begin alu_sel = 2'b00; ld_a   = 1'b1; pc_inc = 1'b1; end
                    OP_MOV_AB: begin alu_sel = 2'b01; ld_a   = 1'b1; pc_inc = 1'b1; end
                    OP_IN_A:   begin alu_sel = 2'b10; ld_a   = 1'b1; pc_inc = 1'b1; end
                    OP_MOV_AI: begin alu_sel = 2'b11; ld_a   = 1'b1; pc_inc = 1'b1; end
                    OP_MOV_BA: begin alu_sel = 2'b00; ld_b   = 1'b1; pc_inc = 1'b1; end
                    OP_ADD_B:  begin alu_sel = 2'b01; ld_b   = 1'b1; pc_inc = 1'b1; end
                    OP_IN_B:   begin alu_sel = 2'b10; ld_b   = 1'b1; pc_inc = 1'b1; end
                    OP_MOV_BI: begin alu_sel = 2'b11; ld_b   = 1'b1; pc_inc = 1'b1; end
                    OP_OUT_B:  begin alu_sel = 2'b01; ld_out = 1'b1; pc_inc = 1'b1; end
                    OP_OUT_I:  begin alu_sel = 2'b11; ld_out = 1'b1; pc_inc = 1'b1; end
                    OP_JNC, OP_JMP: begin
                        alu_sel = 2'b11;
                        pc_ld_n = ~w_jump_taken;
                        pc_inc  = ~w_jump_taken;
                    end
                    default:   begin alu_sel = 2'b11; pc_inc = 1'b1; end
                endcase
            end
            default: begin
                w_next = r_state;
            end
        endcase
    end

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Multi-cycle fetch/execute controller for the TD4 4-bit CPU core. It latches the 8-bit instruction addressed by the program counter, decodes it, and issues one-cycle load strobes to registers A, B and OUT and to the program counter. It also holds the carry flag and decides JNC. The block supports free-run and single-step execution and sits between the instruction ROM, the ALU/source mux and the 4-bit program counter.

## Interface
Parameters:
- PC_W, 4, program-counter / immediate width (TD4 fixed at 4; opcode is always 4 bits)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- run  input  1  1 = free-run, 0 = pause after current instruction
- step  input  1  synchronous; rising edge executes one instruction while paused
- instr  input  8  ROM data at address pc: [7:4] opcode, [3:0] immediate
- pc  input  PC_W  current program-counter value
- carry_in  input  1  ALU carry-out of (source + imm)
- alu_sel  output  2  ALU source: 00=A, 01=B, 10=IN port, 11=zero
- imm  output  PC_W  immediate field of latched instruction
- ld_a  output  1  load A from ALU result (one-cycle strobe)
- ld_b  output  1  load B from ALU result
- ld_out  output  1  load OUT from ALU result
- pc_ld_n  output  1  active-low PC load from ALU result (matches counter ld polarity)
- pc_inc  output  1  PC count-enable strobe
- c_flag  output  1  carry flag
- busy  output  1  1 in FETCH or EXEC
- halted  output  1  1 in HALT (see Configuration)

## Operation
- States: PAUSE, FETCH, EXEC, HALT.
- PAUSE: no strobes. Go to FETCH if run=1 or a step rising edge is detected. The edge is detected against a step_q register, which is updated every cycle.
- FETCH: ir <= instr. No strobes. Go to EXEC.
- EXEC: strobes are decoded from ir. At the end of the cycle, go to FETCH if run=1, else PAUSE. In HALT_DETECT_EN builds, a detected halt goes to HALT instead.
- Decode (opcode -> alu_sel, strobe):
  - 0000 ADD A,Im -> 00, ld_a
  - 0001 MOV A,B -> 01, ld_a
  - 0010 IN A -> 10, ld_a
  - 0011 MOV A,Im -> 11, ld_a
  - 0100 MOV B,A -> 00, ld_b
  - 0101 ADD B,Im -> 01, ld_b
  - 0110 IN B -> 10, ld_b
  - 0111 MOV B,Im -> 11, ld_b
  - 1001 OUT B -> 01, ld_out
  - 1011 OUT Im -> 11, ld_out
  - 1110 JNC Im -> 11, pc_ld_n=0 if c_flag=0, otherwise pc_inc
  - 1111 JMP Im -> 11, pc_ld_n=0
  - any other opcode -> NOP: alu_sel=11, no register strobe, pc_inc
- Every non-jump instruction, and a JNC that is not taken, asserts pc_inc in EXEC. pc_ld_n=0 and pc_inc are never both active.
- Carry flag:
  - At the end of EXEC, c_flag <= carry_in for opcodes 0000 and 0101.
  - c_flag <= 0 for every other opcode.
  - JNC tests the c_flag value from before its own EXEC, i.e. the carry left by the previous instruction.
- run falling mid-instruction: the instruction completes, then the block enters PAUSE.
- A step edge while run=1 is ignored; step_q still tracks.
- imm = ir[3:0] in all states.

## Timing
- Two cycles per instruction: FETCH then EXEC. In free-run, EXEC is followed immediately by FETCH.
- Strobes are active only during EXEC, exactly one cycle. They are combinational from state and ir, with no dependency on inputs except c_flag.
- The PC updates on the clock edge that ends EXEC. The next FETCH sees the new pc/instr.
- From PAUSE, a step edge sampled on cycle n gives FETCH at n+1 and EXEC at n+2, then PAUSE at n+3.
- Reset (asynchronous, any state):
  - state=PAUSE, ir=0, c_flag=0, step_q=0
  - ld_a=ld_b=ld_out=pc_inc=0, pc_ld_n=1, alu_sel=11, imm=0, busy=0, halted=0
- Reset mid-EXEC suppresses that cycle's strobes immediately.

## Configuration
- HALT_DETECT_EN defined:
  - In EXEC, a JMP (1111) with imm == pc, or a taken JNC with imm == pc, still asserts pc_ld_n=0 for its cycle, then enters HALT instead of FETCH/PAUSE.
  - HALT: halted=1, busy=0, all strobes inactive. The block stays in HALT until reset; run and step are ignored.
- HALT_DETECT_EN undefined:
  - The HALT state is absent and halted is tied to 0.
  - A jump-to-self loops normally, two cycles per iteration.

## Test plan
- Reset, run=1, ROM[0]=0x35 (MOV A,5) -> FETCH cycle 1; EXEC cycle 2 with ld_a=1, alu_sel=11, imm=5, pc_inc=1; c_flag=0.
- ADD A,0xF with carry_in=1, then JNC 0x8 -> ADD EXEC sets c_flag=1; JNC EXEC gives pc_inc=1, pc_ld_n=1 (not taken), and c_flag cleared to 0.
- ADD A,1 with carry_in=0, then JNC 0x8 -> JNC EXEC gives pc_ld_n=0, imm=8, pc_inc=0.
- run=0, pulse step twice with 5 idle cycles between -> exactly two FETCH/EXEC pairs, two pc_inc strobes, busy=0 between.
- HALT_DETECT_EN builds: pc=3, ROM[3]=0xF3 -> pc_ld_n=0 for one cycle, then halted=1 with no strobes for 20 cycles; reset gives halted=0 and PAUSE. Undefined builds: same program loops, with pc_ld_n pulsing every 2 cycles.
- Reset asserted during EXEC of 0x40 (MOV B,A) -> ld_b drops to 0 asynchronously, state=PAUSE, c_flag=0.
